store_unit: RTL and testbench
=============================

# store_unit

Data-memory write path for the pipelined core, the store counterpart of the writeback load-extraction logic. It accepts store requests from the MEM stage, aligns the store data and computes byte enables for sb/sh/sw, and buffers them in a small FIFO. It drains the buffer to the data-memory write port with a request/response handshake. It also flags loads whose word address matches a pending store, so the hazard unit can stall them.

## Interface
- DEPTH, 2, store-buffer entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  store request from MEM stage
- req_ready  out  1  buffer can accept; equals !full
- req_funct3  in  3  000 sb, 001 sh, 010 sw; other values are dropped
- req_addr  in  32  byte address (alu_out)
- req_data  in  32  rs2 value
- dmem_write  out  1  write request to data memory
- dmem_address  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  32  aligned write data
- dmem_mbe  out  4  byte enables
- dmem_resp  in  1  write complete, 1-cycle pulse
- ld_valid  in  1  a load is in MEM
- ld_addr  in  32  load byte address
- ld_hazard  out  1  load word matches a buffered store
- busy  out  1  buffer non-empty or write in flight
- misalign  out  1  only with STORE_MISALIGN_TRAP_EN; 1-cycle pulse

## Operation
- Accept on req_valid && req_ready at a rising edge. Formatting happens at enqueue; the entry stores {word addr, wdata, mbe}.
- off = req_addr[1:0]; wdata = req_data << (8*off).
- sb: base mask 0001. sh: base mask 0011. sw: base mask 1111. mbe = (base << off) truncated to 4 bits.
- Legal offsets: sb any; sh 00/01/10; sw 00. Anything else is misaligned (see Configuration).
- Invalid funct3 is accepted (handshake completes) and discarded. Nothing is enqueued and no write is issued.
- FIFO: head and tail pointers wrap at DEPTH; a count tracks occupancy from 0 to DEPTH. When full, req_ready=0, even if a pop occurs in the same cycle.
- Drain FSM:
  - IDLE: if count>0, go to WRITE.
  - WRITE: drive the head entry with dmem_write=1; outputs are held stable until dmem_resp.
  - On dmem_resp, pop. If count after the pop is >0, stay in WRITE and present the next head on the following cycle. Otherwise go to IDLE with dmem_write=0.
- dmem_resp outside WRITE is ignored.
- Simultaneous enqueue and pop (not full): count is unchanged, and both pointers advance.
- ld_hazard = ld_valid && (some valid entry has word address == ld_addr[31:2]). This includes the entry currently being written. It is combinational and excludes a request being enqueued in the same cycle.
- busy = (count != 0).

## Timing
- Reset values: dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_mbe=0, busy=0, ld_hazard=0, misalign=0, req_ready=1. FIFO is empty and the FSM is in IDLE.
- Reset mid-write: the in-flight write is abandoned and all buffered entries are lost. dmem_write drops asynchronously.
- dmem_* outputs are registered. A store enqueued at edge N appears with dmem_write=1 in cycle N+1 when the buffer was empty.
- Back-to-back drain: with resp in cycle K, the next entry is driven in cycle K+1 with no bubble.
- Full recovery: after a pop at edge P, req_ready=1 in cycle P+1.
- ld_hazard is valid in the same cycle as ld_valid/ld_addr.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - A misaligned store is accepted and not enqueued.
  - misalign pulses high for the cycle after acceptance.
  - No memory write occurs.
- STORE_MISALIGN_TRAP_EN undefined:
  - The misalign port is absent.
  - A misaligned store is enqueued with the truncated mask, e.g. sh@11 gives mbe=1000, and sw@01 gives mbe=1110 with wdata=req_data<<8.

## Test plan
- sb addr=0x1003 data=0x000000A5 -> dmem_address=0x1000, wdata=0xA5000000, mbe=1000; dmem_write held until resp 3 cycles later; busy falls the cycle after resp.
- sh addr=0x2001 data=0x0000BEEF -> wdata=0x00BEEF00, mbe=0110; sw addr=0x3000 data=0xDEADBEEF -> mbe=1111.
- DEPTH=2: three stores on consecutive cycles with resp held low -> req_ready=0 after the second; third accepted only the cycle after first resp; writes appear in order without bubbles.
- Pending sw at 0x4000, load ld_addr=0x4002 -> ld_hazard=1; ld_addr=0x4004 -> 0; hazard clears the cycle after the resp pop.
- sh addr=0x5003: with macro, misalign=1 for one cycle and no dmem_write; without macro, a write with mbe=1000, wdata=0xEF000000 for data 0x0000BEEF.
- rst asserted while dmem_write=1 with two entries buffered -> all outputs return to reset values immediately; no further writes after release.

Source files
------------

// File: rtl/store_unit_if.sv
// store_unit_if: MEM-stage store request, data-memory write port and load-hazard probe.
// Latency: pure wiring, no state.
// Backpressure: req_ready and the dmem_write/dmem_resp pair; master = environment, slave = store_unit.
interface store_unit_if;
   // store request from the MEM stage
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   // data-memory write port
   logic        dmem_write;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_mbe;
   logic        dmem_resp;
   // load-hazard probe and status
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        busy;
`ifdef STORE_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   modport master (
      output req_valid, req_funct3, req_addr, req_data, dmem_resp, ld_valid, ld_addr,
      input  req_ready, dmem_write, dmem_address, dmem_wdata, dmem_mbe, ld_hazard, busy
`ifdef STORE_MISALIGN_TRAP_EN
      , input misalign
`endif
   );

   modport slave (
      input  req_valid, req_funct3, req_addr, req_data, dmem_resp, ld_valid, ld_addr,
      output req_ready, dmem_write, dmem_address, dmem_wdata, dmem_mbe, ld_hazard, busy
`ifdef STORE_MISALIGN_TRAP_EN
      , output misalign
`endif
   );
endinterface

// File: rtl/store_unit.sv
// store_unit: formats sb/sh/sw stores (aligned data + byte enables), buffers them in a
// DEPTH-entry FIFO and drains them in order to data memory. Optional macro: STORE_MISALIGN_TRAP_EN.
// Latency: store into an empty buffer drives dmem_write the next cycle; back-to-back drain has no
// bubble. Backpressure: req_ready = !full (a same-cycle pop does not open a slot); dmem_write holds
// its outputs until dmem_resp.
module store_unit #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   store_unit_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   // buffer storage: word address, aligned write data, byte enables
   logic [29:0]   r_ent_addr  [DEPTH];
   logic [31:0]   r_ent_wdata [DEPTH];
   logic [3:0]    r_ent_mbe   [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   // drain FSM and its registered memory-port outputs
   state_t        r_state;
   logic          r_dmem_write;
   logic [31:0]   r_dmem_address;
   logic [31:0]   r_dmem_wdata;
   logic [3:0]    r_dmem_mbe;

   // request formatting
   logic [1:0]    w_off;
   logic [3:0]    w_base;
   logic          w_legal_f3;
   logic          w_misaligned;
   logic [29:0]   w_fmt_addr;
   logic [31:0]   w_fmt_wdata;
   logic [3:0]    w_fmt_mbe;

   // handshake / buffer control
   logic          w_full;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   // next entry to present on the memory port
   logic [PW-1:0] w_src_idx;
   logic          w_src_from_buf;
   logic          w_have_next;
   logic [29:0]   w_src_addr;
   logic [31:0]   w_src_wdata;
   logic [3:0]    w_src_mbe;

   // load hazard
   logic [PW-1:0] w_rel;
   logic          w_hit;
   logic          w_ld_unused;

   // Decode funct3 and align data/mask to the byte offset; the 4-bit shift drops lanes past byte 3.
   always_comb begin
      w_off        = bus.req_addr[1:0];
      w_fmt_addr   = bus.req_addr[31:2];
      w_fmt_wdata  = bus.req_data << {w_off, 3'b000};
      w_base       = 4'b0000;
      w_legal_f3   = 1'b0;
      w_misaligned = 1'b0;
      case (bus.req_funct3)
         3'b000: begin
            w_base     = 4'b0001;
            w_legal_f3 = 1'b1;
         end
         3'b001: begin
            w_base       = 4'b0011;
            w_legal_f3   = 1'b1;
            w_misaligned = (w_off == 2'b11);
         end
         3'b010: begin
            w_base       = 4'b1111;
            w_legal_f3   = 1'b1;
            w_misaligned = (w_off != 2'b00);
         end
         default: begin
            w_base     = 4'b0000;
            w_legal_f3 = 1'b0;
         end
      endcase
      w_fmt_mbe = w_base << w_off;
   end

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_accept = bus.req_valid && !w_full;
   // In WRITE the buffer is never empty, so every response retires the head entry.
   assign w_pop    = (r_state == S_WRITE) && bus.dmem_resp;

`ifdef STORE_MISALIGN_TRAP_EN
   logic r_misalign;

   // Misaligned stores complete the handshake, are dropped, and raise a one-cycle trap pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_accept && w_legal_f3 && w_misaligned;
      end
   end

   assign w_push       = w_accept && w_legal_f3 && !w_misaligned;
   assign bus.misalign = r_misalign;
`else
   logic w_misalign_unused;

   // Without the trap, misaligned stores go to memory with the truncated mask.
   assign w_push            = w_accept && w_legal_f3;
   assign w_misalign_unused = w_misaligned;
`endif

   // Head/tail wrap naturally at DEPTH (power of two); count spans 0..DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry payload needs no reset: validity is carried entirely by head/count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ent_addr[r_tail]  <= w_fmt_addr;
         r_ent_wdata[r_tail] <= w_fmt_wdata;
         r_ent_mbe[r_tail]   <= w_fmt_mbe;
      end
   end

   // Choose what the port shows next: the buffered entry after the current one, or the request
   // being enqueued this cycle when nothing else is queued (bypass keeps the one-cycle latency).
   always_comb begin
      w_src_idx      = r_head;
      w_src_from_buf = 1'b0;
      if (r_state == S_WRITE) begin
         w_src_idx      = r_head + PW'(1);
         w_src_from_buf = (r_count > CW'(1));
      end else begin
         w_src_idx      = r_head;
         w_src_from_buf = (r_count != '0);
      end
      w_have_next = w_src_from_buf || w_push;
      if (w_src_from_buf) begin
         w_src_addr  = r_ent_addr[w_src_idx];
         w_src_wdata = r_ent_wdata[w_src_idx];
         w_src_mbe   = r_ent_mbe[w_src_idx];
      end else begin
         w_src_addr  = w_fmt_addr;
         w_src_wdata = w_fmt_wdata;
         w_src_mbe   = w_fmt_mbe;
      end
   end

   // Drain FSM: hold the head entry on the port until dmem_resp, then advance or fall idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_dmem_write   <= 1'b0;
         r_dmem_address <= '0;
         r_dmem_wdata   <= '0;
         r_dmem_mbe     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_have_next) begin
                  r_state        <= S_WRITE;
                  r_dmem_write   <= 1'b1;
                  r_dmem_address <= {w_src_addr, 2'b00};
                  r_dmem_wdata   <= w_src_wdata;
                  r_dmem_mbe     <= w_src_mbe;
               end
            end
            S_WRITE: begin
               if (w_pop) begin
                  if (w_have_next) begin
                     r_dmem_address <= {w_src_addr, 2'b00};
                     r_dmem_wdata   <= w_src_wdata;
                     r_dmem_mbe     <= w_src_mbe;
                  end else begin
                     r_state      <= S_IDLE;
                     r_dmem_write <= 1'b0;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_dmem_write <= 1'b0;
            end
         endcase
      end
   end

   // Word-address match against every occupied slot, including the one being written.
   always_comb begin
      w_hit = 1'b0;
      w_rel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_rel = PW'(i) - r_head;
         if ((CW'(w_rel) < r_count) && (r_ent_addr[i] == bus.ld_addr[31:2])) begin
            w_hit = 1'b1;
         end
      end
   end

   assign w_ld_unused      = ^bus.ld_addr[1:0];
   assign bus.ld_hazard    = bus.ld_valid && w_hit;
   assign bus.req_ready    = !w_full;
   assign bus.busy         = (r_count != '0);
   assign bus.dmem_write   = r_dmem_write;
   assign bus.dmem_address = r_dmem_address;
   assign bus.dmem_wdata   = r_dmem_wdata;
   assign bus.dmem_mbe     = r_dmem_mbe;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed vector table, hand-written corner sequences and a random run
// against a queue-based reference model of the store buffer.
module tb_store_unit;
   localparam int DEPTH = 2;
`ifdef STORE_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   store_unit_if bus();
   store_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_mbe;
      bit          e_write;
      bit          e_mis;
   } vec_t;

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  m;
   } ent_t;

   vec_t vt [10];
   ent_t q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_data   = '0;
      bus.dmem_resp  = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
   endtask

   task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_data   = d;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " dmem_write"}, bus.dmem_write, 0);
      chk({tag, " dmem_address"}, bus.dmem_address, 0);
      chk({tag, " dmem_wdata"}, bus.dmem_wdata, 0);
      chk({tag, " dmem_mbe"}, bus.dmem_mbe, 0);
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " ld_hazard"}, bus.ld_hazard, 0);
      chk({tag, " req_ready"}, bus.req_ready, 1);
`ifdef STORE_MISALIGN_TRAP_EN
      chk({tag, " misalign"}, bus.misalign, 0);
`endif
   endtask

   // Reference formatting from the byte-lane rules: a store of N bytes at offset off
   // covers lanes off..off+N-1 of the word; lanes beyond the word are dropped.
   function automatic ent_t model_fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      ent_t r;
      int off    = int'(a % 4);
      int nbytes = 1 << f3;
      logic [63:0] wide = {32'h0, d} << (8 * off);
      int mask = ((1 << nbytes) - 1) << off;
      r.w = 30'(a >> 2);
      r.d = wide[31:0];
      r.m = 4'(mask);
      return r;
   endfunction

   function automatic bit model_fits(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a % 4) + (1 << f3)) <= 4;
   endfunction

   // Absolute time bound so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic        r_rv, r_resp, r_ldv, r_hz, r_acc;
   logic [2:0]  r_f3;
   logic [31:0] r_addr, r_data, r_ld;
`ifdef STORE_MISALIGN_TRAP_EN
   logic        exp_mis;
`endif

   initial begin
      vt[0] = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 32'hA500_0000, 4'b1000, 1'b1, 1'b0};
      vt[1] = '{3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'h0000_2000, 32'h00BE_EF00, 4'b0110, 1'b1, 1'b0};
      vt[2] = '{3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0};
      vt[3] = '{3'b000, 32'h0000_0010, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678, 4'b0001, 1'b1, 1'b0};
      vt[4] = '{3'b001, 32'h0000_0022, 32'h0000_CAFE, 32'h0000_0020, 32'hCAFE_0000, 4'b1100, 1'b1, 1'b0};
      vt[5] = '{3'b000, 32'h0000_0041, 32'h0000_00FF, 32'h0000_0040, 32'h0000_FF00, 4'b0010, 1'b1, 1'b0};
      vt[6] = '{3'b011, 32'h0000_0050, 32'h1111_1111, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
      vt[7] = '{3'b111, 32'h0000_0060, 32'h2222_2222, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
      vt[8] = '{3'b001, 32'h0000_5003, 32'h0000_BEEF, 32'h0000_5000, 32'hEF00_0000, 4'b1000, !TRAP, TRAP};
      vt[9] = '{3'b010, 32'h0000_6001, 32'h1122_3344, 32'h0000_6000, 32'h2233_4400, 4'b1110, !TRAP, TRAP};

      // ---- reset values (probe a load to prove ld_hazard is quiet) ----
      idle_inputs();
      bus.ld_valid = 1'b1;
      #3;
      chk_reset_vals("reset");
      cyc();
      cyc();
      rst = 1'b0;
      bus.ld_valid = 1'b0;
      cyc();

      // ---- vector table: formatting, handshake hold, busy fall ----
      for (int i = 0; i < 10; i++) begin
         set_req(vt[i].f3, vt[i].addr, vt[i].data);
         cyc();
         bus.req_valid = 1'b0;
         #1;
         chk($sformatf("v%0d dmem_write", i), bus.dmem_write, vt[i].e_write);
`ifdef STORE_MISALIGN_TRAP_EN
         chk($sformatf("v%0d misalign", i), bus.misalign, vt[i].e_mis);
`endif
         if (vt[i].e_write) begin
            chk($sformatf("v%0d dmem_address", i), bus.dmem_address, vt[i].e_addr);
            chk($sformatf("v%0d dmem_wdata", i), bus.dmem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d dmem_mbe", i), bus.dmem_mbe, vt[i].e_mbe);
            chk($sformatf("v%0d busy", i), bus.busy, 1);
            cyc();
            cyc();
            chk($sformatf("v%0d write held", i), bus.dmem_write, 1);
            chk($sformatf("v%0d wdata held", i), bus.dmem_wdata, vt[i].e_wdata);
            bus.dmem_resp = 1'b1;
            cyc();
            bus.dmem_resp = 1'b0;
            #1;
            chk($sformatf("v%0d write dropped", i), bus.dmem_write, 0);
            chk($sformatf("v%0d busy dropped", i), bus.busy, 0);
         end else begin
            chk($sformatf("v%0d busy idle", i), bus.busy, 0);
            cyc();
            #1;
            chk($sformatf("v%0d still no write", i), bus.dmem_write, 0);
`ifdef STORE_MISALIGN_TRAP_EN
            chk($sformatf("v%0d misalign pulse end", i), bus.misalign, 0);
`endif
         end
         cyc();
      end

      // ---- DEPTH=2 full: third store waits for the first response ----
      set_req(3'b010, 32'h0000_0100, 32'hAAAA_0001);
      cyc();
      set_req(3'b010, 32'h0000_0104, 32'hAAAA_0002);
      #1;
      chk("full ready after 1", bus.req_ready, 1);
      cyc();
      set_req(3'b010, 32'h0000_0108, 32'hAAAA_0003);
      #1;
      chk("full ready after 2", bus.req_ready, 0);
      chk("full first addr", bus.dmem_address, 32'h0000_0100);
      cyc();
      #1;
      chk("full still blocked", bus.req_ready, 0);
      chk("full first held", bus.dmem_address, 32'h0000_0100);
      bus.dmem_resp = 1'b1;
      cyc();
      bus.dmem_resp = 1'b0;
      #1;
      chk("full ready after pop", bus.req_ready, 1);
      chk("full second no bubble", bus.dmem_write, 1);
      chk("full second addr", bus.dmem_address, 32'h0000_0104);
      cyc();
      bus.req_valid = 1'b0;
      #1;
      chk("full third taken", bus.req_ready, 0);
      bus.dmem_resp = 1'b1;
      cyc();
      #1;
      chk("full third addr", bus.dmem_address, 32'h0000_0108);
      chk("full third wdata", bus.dmem_wdata, 32'hAAAA_0003);
      chk("full third write", bus.dmem_write, 1);
      cyc();
      bus.dmem_resp = 1'b0;
      #1;
      chk("full drained", bus.dmem_write, 0);
      chk("full busy", bus.busy, 0);
      cyc();

      // ---- load hazard ----
      set_req(3'b010, 32'h0000_7000, 32'h0);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h0000_7000;
      #1;
      chk("hz same-cycle enqueue", bus.ld_hazard, 0);
      cyc();
      bus.req_valid = 1'b0;
      #1;
      chk("hz in-flight entry", bus.ld_hazard, 1);
      bus.dmem_resp = 1'b1;
      cyc();
      bus.dmem_resp = 1'b0;
      #1;
      chk("hz cleared 7000", bus.ld_hazard, 0);
      set_req(3'b010, 32'h0000_4000, 32'h1234_0000);
      bus.ld_valid = 1'b0;
      cyc();
      bus.req_valid = 1'b0;
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 32'h0000_4002;
      #1;
      chk("hz 4002", bus.ld_hazard, 1);
      bus.ld_addr = 32'h0000_4004;
      #1;
      chk("hz 4004", bus.ld_hazard, 0);
      bus.ld_addr  = 32'h0000_4000;
      bus.ld_valid = 1'b0;
      #1;
      chk("hz no ld_valid", bus.ld_hazard, 0);
      bus.ld_valid = 1'b1;
      bus.dmem_resp = 1'b1;
      #1;
      chk("hz before pop", bus.ld_hazard, 1);
      cyc();
      bus.dmem_resp = 1'b0;
      #1;
      chk("hz after pop", bus.ld_hazard, 0);
      bus.ld_valid = 1'b0;
      cyc();

      // ---- reset during an in-flight write with a full buffer ----
      set_req(3'b010, 32'h0000_9000, 32'h5555_5555);
      cyc();
      set_req(3'b010, 32'h0000_9004, 32'h6666_6666);
      cyc();
      bus.req_valid = 1'b0;
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 32'h0000_9004;
      #1;
      chk("rstmid write before", bus.dmem_write, 1);
      chk("rstmid hazard before", bus.ld_hazard, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals("rstmid");
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.dmem_resp = k[0];
         #1;
         chk($sformatf("rstmid quiet %0d", k), bus.dmem_write, 0);
         chk($sformatf("rstmid busy %0d", k), bus.busy, 0);
         cyc();
      end
      idle_inputs();
      cyc();

      // ---- random traffic against the queue model ----
`ifdef STORE_MISALIGN_TRAP_EN
      exp_mis = 1'b0;
`endif
      for (int c = 0; c < 800; c++) begin
         r_rv   = ($urandom_range(0, 2) != 0);
         r_f3   = 3'($urandom_range(0, 4));
         r_addr = 32'h0000_8000 + 32'($urandom_range(0, 31));
         r_data = $urandom;
         r_resp = ($urandom_range(0, 2) == 0);
         r_ldv  = 1'($urandom_range(0, 1));
         r_ld   = 32'h0000_8000 + 32'($urandom_range(0, 31));
         bus.req_valid  = r_rv;
         bus.req_funct3 = r_f3;
         bus.req_addr   = r_addr;
         bus.req_data   = r_data;
         bus.dmem_resp  = r_resp;
         bus.ld_valid   = r_ldv;
         bus.ld_addr    = r_ld;
         #1;
         chk("rnd req_ready", bus.req_ready, (q.size() < DEPTH));
         chk("rnd busy", bus.busy, (q.size() != 0));
         chk("rnd dmem_write", bus.dmem_write, (q.size() != 0));
         if (q.size() != 0) begin
            chk("rnd dmem_address", bus.dmem_address, {q[0].w, 2'b00});
            chk("rnd dmem_wdata", bus.dmem_wdata, q[0].d);
            chk("rnd dmem_mbe", bus.dmem_mbe, q[0].m);
         end
         r_hz = 1'b0;
         foreach (q[k]) if (q[k].w == 30'(r_ld >> 2)) r_hz = 1'b1;
         chk("rnd ld_hazard", bus.ld_hazard, r_ldv && r_hz);
`ifdef STORE_MISALIGN_TRAP_EN
         chk("rnd misalign", bus.misalign, exp_mis);
`endif
         r_acc = r_rv && (q.size() < DEPTH);
         if (r_resp && q.size() > 0) void'(q.pop_front());
         if (r_acc && r_f3 <= 3'd2 && (model_fits(r_f3, r_addr) || !TRAP))
            q.push_back(model_fmt(r_f3, r_addr, r_data));
`ifdef STORE_MISALIGN_TRAP_EN
         exp_mis = r_acc && r_f3 <= 3'd2 && !model_fits(r_f3, r_addr);
`endif
         cyc();
      end

      idle_inputs();
      bus.dmem_resp = 1'b1;
      for (int k = 0; k < DEPTH + 2; k++) cyc();
      bus.dmem_resp = 1'b0;
      #1;
      chk("final idle", bus.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
